input_judge: RTL and testbench
==============================

# input_judge

Judges each player key press against the tile in the hit row (line 6) and initiates the matching draw request. On a correct press it starts the correct-input drawer, which paints the square white. On a wrong press it starts the wrong-input drawer. After the drawer reports done, it clears line 6 and updates the score and miss counters. It sits between the keyboard/KEY decoder and the go/done drawing blocks, acting as the initiator side of their handshake.

## Interface
Parameters:
- MAX_MISSES, 3: wrong presses that end the game (1..15)
- SCORE_W, 10: score counter width

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- key_valid  input  1  one-cycle pulse: a lane key was pressed
- key_lane  input  2  lane of the press (0..3)
- line_6  input  3  hit-row tile: 0..3 = tile lane; 4..7 = row empty
- offset  input  6  current scroll offset, forwarded to the drawers
- correct_done  input  1  one-cycle pulse from the correct drawer
- wrong_done  input  1  one-cycle pulse from the wrong drawer
- correct_go  output  1  one-cycle start pulse to the correct drawer
- wrong_go  output  1  one-cycle start pulse to the wrong drawer
- draw_line  output  3  line_6 latched at the press, held while busy
- draw_offset  output  6  offset latched at the press, held while busy
- clear_line6  output  1  one-cycle pulse: clear line 6 of the tile register
- score  output  SCORE_W  correct presses, saturating
- misses  output  4  wrong presses
- busy  output  1  high in any state other than IDLE and OVER
- game_over  output  1  high in OVER

## Operation
- States: IDLE, REQ_C, WAIT_C, CLEAR, REQ_W, WAIT_W, OVER.
- IDLE, key_valid=1, line_6<4:
  - Latch line_6 and offset into draw_line and draw_offset.
  - If key_lane==line_6[1:0], go to REQ_C; otherwise go to REQ_W.
- IDLE, key_valid=1, line_6>=4 (empty row): behaviour is set by the Configuration macro.
- REQ_C: correct_go=1 for this cycle only, then WAIT_C.
- WAIT_C: hold until correct_done=1, then CLEAR.
- CLEAR:
  - clear_line6=1 for this cycle only.
  - score increments, saturating at 2^SCORE_W-1.
  - Next state IDLE.
- REQ_W: wrong_go=1 for this cycle only, then WAIT_W.
- WAIT_W: hold until wrong_done=1.
  - misses increments.
  - If the new value equals MAX_MISSES, go to OVER; otherwise go to IDLE.
  - line 6 is not cleared on a miss.
- OVER: terminal. All inputs are ignored; only reset leaves it.
- key_valid is ignored outside IDLE. Such presses are dropped, not queued, and not counted.
- correct_done and wrong_done are honoured only in WAIT_C and WAIT_W respectively; in every other state they are ignored.
- draw_line and draw_offset stay stable from REQ_* until the state returns to IDLE.

## Timing
- Reset values: state IDLE; correct_go, wrong_go, clear_line6, busy, game_over = 0; score, misses, draw_line, draw_offset = 0.
- Press at edge N (in IDLE): the state is REQ_* during cycle N+1, so go is high in N+1.
- Drawer done seen at edge M:
  - Correct path: clear_line6 is high and score is updated in cycle M+1; IDLE in M+2.
  - Wrong path: misses is updated and the state is IDLE or OVER in M+1.
- Minimum press-to-press spacing: 4 cycles (correct path, done returned at once). Earlier presses are dropped.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset mid-operation (any state) returns to IDLE on the next edge with all outputs at reset values. A stale done from the still-running drawer arrives in IDLE and is ignored.
- The score register wraps never; misses never exceeds MAX_MISSES.

## Configuration
- JUDGE_EMPTY_MISS_EN:
  - Defined: a press when line_6>=4 goes to REQ_W and counts as a miss. The wrong drawer receives the latched line_6 and decides what to draw.
  - Undefined: a press on an empty row is ignored; the state stays IDLE and no go pulse is issued.

## Test plan
- Reset, then press lane 2 with line_6=2 and offset=17; done returned 5 cycles after go → correct_go is a single pulse with draw_line=2 and draw_offset=17; clear_line6 pulses once; score=1; busy falls.
- Press lane 1 with line_6=3 three times (MAX_MISSES=3), each answered with wrong_done → three wrong_go pulses; misses=3; game_over=1; a fourth press produces no go.
- Second key_valid and a spurious wrong_done during WAIT_C → both ignored; only one correct_go; score=1.
- Press with line_6=5 → with the macro, wrong_go pulses and misses=1; without it, no go and state IDLE.
- Force score to 1023 (SCORE_W=10) and make one more correct press → score stays 1023.
- Assert reset in WAIT_C, then deliver correct_done → no clear_line6, score=0, state IDLE.

Source files
------------

// File: rtl/input_judge.sv
// Judges a lane key press against the hit-row tile and drives the correct/wrong drawer
// handshake, then updates score/misses. Optional JUDGE_EMPTY_MISS_EN: empty-row press is a miss.
module input_judge #(
  parameter int MAX_MISSES = 3,
  parameter int SCORE_W    = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [1:0]         key_lane,
  input  logic [2:0]         line_6,
  input  logic [5:0]         offset,
  input  logic               correct_done,
  input  logic               wrong_done,
  output logic               correct_go,
  output logic               wrong_go,
  output logic [2:0]         draw_line,
  output logic [5:0]         draw_offset,
  output logic               clear_line6,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         misses,
  output logic               busy,
  output logic               game_over
);

  typedef enum logic [2:0] {
    IDLE, REQ_C, WAIT_C, CLEAR, REQ_W, WAIT_W, OVER
  } state_t;

  state_t     state, next;
  logic       latch, inc_score, inc_miss;
  logic [3:0] miss_next;

  assign miss_next = misses + 4'd1;

  always_comb begin
    next      = state;
    latch     = 1'b0;
    inc_score = 1'b0;
    inc_miss  = 1'b0;
    case (state)
      IDLE: begin
        if (key_valid) begin
          if (!line_6[2]) begin
            latch = 1'b1;
            next  = (key_lane == line_6[1:0]) ? REQ_C : REQ_W;
          end
`ifdef JUDGE_EMPTY_MISS_EN
          else begin
            latch = 1'b1;
            next  = REQ_W;
          end
`endif
        end
      end
      REQ_C:  next = WAIT_C;
      WAIT_C: if (correct_done) begin
        next      = CLEAR;
        inc_score = 1'b1;
      end
      CLEAR:  next = IDLE;
      REQ_W:  next = WAIT_W;
      WAIT_W: if (wrong_done) begin
        inc_miss = 1'b1;
        next     = (miss_next == 4'(MAX_MISSES)) ? OVER : IDLE;
      end
      OVER:    next = OVER;
      default: next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      draw_line   <= '0;
      draw_offset <= '0;
      score       <= '0;
      misses      <= '0;
      correct_go  <= 1'b0;
      wrong_go    <= 1'b0;
      clear_line6 <= 1'b0;
      busy        <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state <= next;
      if (latch) begin
        draw_line   <= line_6;
        draw_offset <= offset;
      end
      if (inc_score && (score != {SCORE_W{1'b1}}))
        score <= score + 1'b1;
      if (inc_miss)
        misses <= miss_next;
      correct_go  <= (next == REQ_C);
      wrong_go    <= (next == REQ_W);
      clear_line6 <= (next == CLEAR);
      busy        <= (next != IDLE) && (next != OVER);
      game_over   <= (next == OVER);
    end
  end

endmodule

// File: tb/tb_input_judge.sv
// Self-checking bench for input_judge: table of presses plus hand sequences,
// with a go-pulse scoreboard fed at press time and drained when a go appears.
module tb_input_judge;

  logic       clock = 0, reset = 0;
  logic       key_valid = 0, correct_done = 0, wrong_done = 0;
  logic [1:0] key_lane = 0;
  logic [2:0] line_6 = 0;
  logic [5:0] offset = 0;
  logic       correct_go, wrong_go, clear_line6, busy, game_over;
  logic [2:0] draw_line;
  logic [5:0] draw_offset;
  logic [9:0] score;
  logic [3:0] misses;

  input_judge #(.MAX_MISSES(3), .SCORE_W(10)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_lane(key_lane),
    .line_6(line_6), .offset(offset), .correct_done(correct_done), .wrong_done(wrong_done),
    .correct_go(correct_go), .wrong_go(wrong_go), .draw_line(draw_line),
    .draw_offset(draw_offset), .clear_line6(clear_line6), .score(score),
    .misses(misses), .busy(busy), .game_over(game_over)
  );

  always #5 clock = ~clock;

  typedef struct { bit wrong; logic [2:0] line; logic [5:0] off; } exp_t;
  typedef struct {
    logic [1:0] lane; logic [2:0] line; logic [5:0] off;
    int kind; int score; int misses;
  } vec_t;

  exp_t sb[$];
  int n_checks = 0, n_fail = 0;
  int n_cgo = 0, n_wgo = 0, n_clr = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (clear_line6) n_clr++;
      if (correct_go) n_cgo++;
      if (wrong_go) n_wgo++;
      if (correct_go || wrong_go) begin
        if (sb.size() == 0) chk("unexpected_go", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("go_kind_wrong", int'(wrong_go), int'(e.wrong));
          chk("draw_line", int'(draw_line), int'(e.line));
          chk("draw_offset", int'(draw_offset), int'(e.off));
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0;
  endtask

  task automatic press(input logic [1:0] lane, input logic [2:0] line, input logic [5:0] off);
    @(posedge clock); #1;
    key_valid = 1; key_lane = lane; line_6 = line; offset = off;
    @(posedge clock); #1 key_valid = 0;
  endtask

  task automatic wait_go(input int bound, output int kind);
    kind = 0;
    for (int i = 0; i < bound && kind == 0; i++) begin
      @(negedge clock);
      if (correct_go) kind = 1;
      else if (wrong_go) kind = 2;
    end
  endtask

  task automatic pulse_done(input int kind);
    @(posedge clock); #1;
    if (kind == 1) correct_done = 1; else wrong_done = 1;
    @(posedge clock); #1 correct_done = 0; wrong_done = 0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clock);
      if (!busy) done = 1;
    end
    if (!done) chk("busy_timeout", 1, 0);
  endtask

  // kind: 0 = no go expected, 1 = correct, 2 = wrong
  task automatic run_press(input logic [1:0] lane, input logic [2:0] line,
                           input logic [5:0] off, input int delay, input int kind);
    int got;
    exp_t e;
    if (kind != 0) begin
      e.wrong = (kind == 2); e.line = line; e.off = off;
      sb.push_back(e);
    end
    press(lane, line, off);
    wait_go(10, got);
    if (kind != 0) begin
      if (got == 0) chk("go_timeout", 0, 1);
      else begin
        repeat (delay) @(posedge clock);
        pulse_done(got);
        wait_idle();
      end
    end
  endtask

  vec_t vecs[5];
  int clr0, cgo0, wgo0, got;

  initial begin
    vecs[0] = '{2'd2, 3'd2, 6'd17, 1, 1, 0};
    vecs[1] = '{2'd0, 3'd3, 6'd5,  2, 1, 1};
    vecs[2] = '{2'd3, 3'd3, 6'd63, 1, 2, 1};
    vecs[3] = '{2'd1, 3'd0, 6'd0,  2, 2, 2};
    vecs[4] = '{2'd0, 3'd0, 6'd33, 1, 3, 2};

    do_reset();
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_score", score, 0);
    chk("rst_misses", misses, 0);
    chk("rst_draw_line", draw_line, 0);
    chk("rst_go", int'(correct_go | wrong_go | clear_line6), 0);

    foreach (vecs[i]) begin
      clr0 = n_clr;
      run_press(vecs[i].lane, vecs[i].line, vecs[i].off, (i == 0) ? 5 : 1, vecs[i].kind);
      chk("vec_score", score, vecs[i].score);
      chk("vec_misses", misses, vecs[i].misses);
      chk("vec_busy", busy, 0);
      chk("vec_clear_count", n_clr - clr0, (vecs[i].kind == 1) ? 1 : 0);
    end

    // Extra press and stray wrong_done while waiting on the correct drawer
    do_reset();
    cgo0 = n_cgo; wgo0 = n_wgo;
    sb.push_back('{1'b0, 3'd1, 6'd9});
    press(2'd1, 3'd1, 6'd9);
    wait_go(10, got);
    chk("spur_go", got, 1);
    @(posedge clock); #1 key_valid = 1; key_lane = 2'd1; wrong_done = 1;
    @(posedge clock); #1 key_valid = 0; wrong_done = 0;
    repeat (2) @(posedge clock);
    pulse_done(1);
    wait_idle();
    repeat (4) @(negedge clock);
    chk("spur_cgo_count", n_cgo - cgo0, 1);
    chk("spur_wgo_count", n_wgo - wgo0, 0);
    chk("spur_score", score, 1);
    chk("spur_misses", misses, 0);

    // Empty hit row
    do_reset();
`ifdef JUDGE_EMPTY_MISS_EN
    run_press(2'd0, 3'd5, 6'd12, 1, 2);
    chk("empty_misses", misses, 1);
`else
    wgo0 = n_wgo;
    run_press(2'd0, 3'd5, 6'd12, 1, 0);
    chk("empty_misses", misses, 0);
    chk("empty_no_go", n_wgo - wgo0, 0);
    chk("empty_busy", busy, 0);
`endif

    // Three misses end the game
    do_reset();
    for (int i = 0; i < 3; i++) run_press(2'd1, 3'd3, 6'd2, 1, 2);
    chk("over_misses", misses, 3);
    chk("over_flag", game_over, 1);
    chk("over_busy", busy, 0);
    run_press(2'd3, 3'd3, 6'd2, 1, 0);
    pulse_done(2);
    repeat (2) @(negedge clock);
    chk("over_misses_hold", misses, 3);
    chk("over_flag_hold", game_over, 1);

    // Score saturation
    do_reset();
    for (int i = 0; i < 1023; i++) run_press(2'd0, 3'd0, 6'd1, 0, 1);
    chk("score_max", score, 1023);
    run_press(2'd0, 3'd0, 6'd1, 0, 1);
    chk("score_saturate", score, 1023);

    // Reset while waiting on the correct drawer; its late done must be ignored
    do_reset();
    clr0 = n_clr;
    sb.push_back('{1'b0, 3'd2, 6'd40});
    press(2'd2, 3'd2, 6'd40);
    wait_go(10, got);
    chk("rst_mid_go", got, 1);
    @(posedge clock); #1 reset = 1;
    @(posedge clock); #1 reset = 0; correct_done = 1;
    @(posedge clock); #1 correct_done = 0;
    repeat (3) @(negedge clock);
    chk("rst_mid_clear", n_clr - clr0, 0);
    chk("rst_mid_score", score, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_draw_off", draw_offset, 0);

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
